univ_shiftreg: RTL and testbench

- Parametrised universal shift register; the next generation of the team's 4-bit right-shift register.
- Adds configurable width, left/right shift, rotate, arithmetic shift, parallel load and synchronous clear.
- Adds a shift counter that flags each time a full word has been shifted.
- Used as a serialiser/deserialiser front-end and as general-purpose datapath storage.

---
 rtl/shreg_pkg.sv | 41 ++++
 rtl/shreg_bitcnt.sv | 56 +++++
 rtl/univ_shiftreg.sv | 88 ++++++++
 tb/tb_univ_shiftreg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// small decode helpers used by the top-level datapath.
package shreg_pkg;

   localparam int unsigned MODE_W = 3;

   // Operation select carried on the mode port.
   typedef logic [MODE_W-1:0] mode_t;

   localparam mode_t MODE_HOLD = 3'b000;
   localparam mode_t MODE_SHR  = 3'b001;
   localparam mode_t MODE_SHL  = 3'b010;
   localparam mode_t MODE_ROR  = 3'b011;
   localparam mode_t MODE_ROL  = 3'b100;
   localparam mode_t MODE_LOAD = 3'b101;
   localparam mode_t MODE_ASR  = 3'b110;
   localparam mode_t MODE_CLR  = 3'b111;

   // Modes that move data by one bit position and advance the shift counter.
   function automatic logic is_counted(input mode_t m);
      logic r;
      r = 1'b0;
      case (m)
         MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: r = 1'b1;
         default:                                          r = 1'b0;
      endcase
      return r;
   endfunction

   // Modes that establish a fresh word and therefore restart the counter.
   function automatic logic is_restart(input mode_t m);
      logic r;
      r = 1'b0;
      case (m)
         MODE_LOAD, MODE_CLR: r = 1'b1;
         default:             r = 1'b0;
      endcase
      return r;
   endfunction

endpackage : shreg_pkg

// File: rtl/shreg_bitcnt.sv
// Modulo-WIDTH shift counter with a registered word-complete pulse.
//
// Ports:
//   clk        rising-edge clock
//   clrb       synchronous active-low reset
//   inc        one counted shift is performed at this edge
//   zero       restart the count at this edge (load/clear); wins over inc
//   bit_cnt    shifts since last restart, modulo WIDTH
//   word_done  high for one cycle after the WIDTH-th counted shift
module shreg_bitcnt #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          clrb,
   input  logic          inc,
   input  logic          zero,
   output logic [CW-1:0] bit_cnt,
   output logic          word_done
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_nxt;
   logic          done_nxt;

   // Next count: wrap at WIDTH-1 so the counter never reaches WIDTH.
   always_comb begin
      cnt_nxt  = bit_cnt;
      done_nxt = 1'b0;
      if (zero) begin
         cnt_nxt  = '0;
         done_nxt = 1'b0;
      end else if (inc) begin
         if (bit_cnt == LAST) begin
            cnt_nxt  = '0;
            done_nxt = 1'b1;
         end else begin
            cnt_nxt  = bit_cnt + CW'(1);
            done_nxt = 1'b0;
         end
      end
   end

   // Reset discards any partial word without raising word_done.
   always_ff @(posedge clk) begin
      if (!clrb) begin
         bit_cnt   <= '0;
         word_done <= 1'b0;
      end else begin
         bit_cnt   <= cnt_nxt;
         word_done <= done_nxt;
      end
   end

endmodule : shreg_bitcnt

// File: rtl/univ_shiftreg.sv
// Parametrised universal shift register: hold, logical/arithmetic shift,
// rotate, parallel load and clear, plus a word-complete shift counter.
//
// Ports:
//   clk        rising-edge clock
//   clrb       synchronous active-low reset (overrides en/mode)
//   en         operation enable; 0 behaves as HOLD
//   mode       operation select (see shreg_pkg)
//   sdr        serial in for right shift, enters at the MSB
//   sdl        serial in for left shift, enters at the LSB
//   pin        parallel load data
//   q          register contents
//   so_r       right-shift serial out, q[0]
//   so_l       left-shift serial out, q[WIDTH-1]
//   bit_cnt    counted shifts since last load/clear, modulo WIDTH
//   word_done  one-cycle pulse after the WIDTH-th counted shift
module univ_shiftreg
   import shreg_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             clrb,
   input  logic             en,
   input  mode_t            mode,
   input  logic             sdr,
   input  logic             sdl,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] q,
   output logic             so_r,
   output logic             so_l,
   output logic [CW-1:0]    bit_cnt,
   output logic             word_done
);

   logic [WIDTH-1:0] q_nxt;
   logic             cnt_inc;
   logic             cnt_zero;

   // Next-state mux for the data register; en low is a plain hold.
   always_comb begin
      q_nxt = q;
      if (en) begin
         case (mode)
            MODE_HOLD: q_nxt = q;
            MODE_SHR:  q_nxt = {sdr, q[WIDTH-1:1]};
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sdl};
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_LOAD: q_nxt = pin;
            MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_nxt = '0;
            default:   q_nxt = q;
         endcase
      end
   end

   // Data register.
   always_ff @(posedge clk) begin
      if (!clrb) begin
         q <= '0;
      end else begin
         q <= q_nxt;
      end
   end

   // Serial outputs follow the register directly.
   assign so_r = q[0];
   assign so_l = q[WIDTH-1];

   // The counter sees operations, not net displacement, so direction
   // changes keep accumulating.
   assign cnt_inc  = en & is_counted(mode);
   assign cnt_zero = en & is_restart(mode);

   shreg_bitcnt #(
      .WIDTH (WIDTH)
   ) u_bitcnt (
      .clk       (clk),
      .clrb      (clrb),
      .inc       (cnt_inc),
      .zero      (cnt_zero),
      .bit_cnt   (bit_cnt),
      .word_done (word_done)
   );

endmodule : univ_shiftreg

// File: tb/tb_univ_shiftreg.sv
// Self-checking bench: 8-bit and 4-bit instances driven in lockstep and
// compared against an arithmetic reference model after every edge.
module tb_univ_shiftreg;
   import shreg_pkg::*;

   logic        clk = 1'b0;
   logic        clrb;
   logic        en;
   mode_t       mode;
   logic        sdr;
   logic        sdl;
   logic [7:0]  pin;

   logic [7:0]  q8;
   logic        so_r8, so_l8, wd8;
   logic [3:0]  bc8;
   logic [3:0]  q4;
   logic        so_r4, so_l4, wd4;
   logic [2:0]  bc4;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: index 0 is the 8-bit instance, index 1 the 4-bit one.
   logic [63:0] mq   [2];
   int          mcnt [2];
   logic        mwd  [2];

   always #5 clk = ~clk;

   univ_shiftreg #(.WIDTH(8)) u8 (
      .clk(clk), .clrb(clrb), .en(en), .mode(mode), .sdr(sdr), .sdl(sdl),
      .pin(pin), .q(q8), .so_r(so_r8), .so_l(so_l8), .bit_cnt(bc8),
      .word_done(wd8)
   );

   univ_shiftreg #(.WIDTH(4)) u4 (
      .clk(clk), .clrb(clrb), .en(en), .mode(mode), .sdr(sdr), .sdl(sdl),
      .pin(pin[3:0]), .q(q4), .so_r(so_r4), .so_l(so_l4), .bit_cnt(bc4),
      .word_done(wd4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Register contents after one operation, from the mode table in arithmetic form.
   function automatic logic [63:0] ref_next(input int w, input logic [63:0] q,
                                            input mode_t m, input logic sr,
                                            input logic sl, input logic [63:0] p);
      logic [63:0] mask;
      logic [63:0] msb;
      mask = (64'd1 << w) - 64'd1;
      msb  = 64'(q[w-1]);
      case (m)
         MODE_SHR:  return (q >> 1) | (64'(sr) << (w - 1));
         MODE_SHL:  return ((q << 1) | 64'(sl)) & mask;
         MODE_ROR:  return (q >> 1) | (64'(q[0]) << (w - 1));
         MODE_ROL:  return ((q << 1) | msb) & mask;
         MODE_ASR:  return (q >> 1) | (msb << (w - 1));
         MODE_LOAD: return p & mask;
         MODE_CLR:  return 64'd0;
         default:   return q;
      endcase
   endfunction

   // Apply one clock of stimulus, advance the model, compare every output.
   task automatic step(input logic c, input logic e, input mode_t m,
                       input logic si_r, input logic si_l, input logic [7:0] p);
      int w;
      clrb = c; en = e; mode = m; sdr = si_r; sdl = si_l; pin = p;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? 8 : 4;
         if (!c) begin
            mq[k] = 64'd0; mcnt[k] = 0; mwd[k] = 1'b0;
         end else begin
            mwd[k] = 1'b0;
            if (e) begin
               mq[k] = ref_next(w, mq[k], m, si_r, si_l, 64'(p));
               if (m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR}) begin
                  mcnt[k] = (mcnt[k] + 1) % w;
                  mwd[k]  = (mcnt[k] == 0);
               end else if (m inside {MODE_LOAD, MODE_CLR}) begin
                  mcnt[k] = 0;
               end
            end
         end
      end
      check("q8",    64'(q8),    mq[0]);
      check("so_r8", 64'(so_r8), 64'(mq[0][0]));
      check("so_l8", 64'(so_l8), 64'(mq[0][7]));
      check("cnt8",  64'(bc8),   64'(mcnt[0]));
      check("wd8",   64'(wd8),   64'(mwd[0]));
      check("q4",    64'(q4),    mq[1]);
      check("so_r4", 64'(so_r4), 64'(mq[1][0]));
      check("so_l4", 64'(so_l4), 64'(mq[1][3]));
      check("cnt4",  64'(bc4),   64'(mcnt[1]));
      check("wd4",   64'(wd4),   64'(mwd[1]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] shr_q   [4];
      logic [2:0] shr_cnt [4];
      logic       shr_sdr [4];
      int         pulses;
      int         last_pulse;
      shr_q   = '{4'h8, 4'h4, 4'hA, 4'hD};
      shr_cnt = '{3'd1, 3'd2, 3'd3, 3'd0};
      shr_sdr = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 2; k++) begin
         mq[k] = 64'd0; mcnt[k] = 0; mwd[k] = 1'b0;
      end
      clrb = 1'b0; en = 1'b1; mode = MODE_LOAD; sdr = 1'b0; sdl = 1'b0; pin = 8'hFF;

      // Reset overrides a pending load.
      step(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
      step(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
      check("rst_q8",   64'(q8),  64'h00);
      check("rst_cnt8", 64'(bc8), 64'd0);
      check("rst_wd8",  64'(wd8), 64'd0);
      step(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
      check("load_a5", 64'(q8), 64'hA5);

      // 4-bit serial-in sequence from reset.
      step(1'b0, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, MODE_SHR, shr_sdr[i], 1'b0, 8'h00);
         check("shr4_q",   64'(q4),  64'(shr_q[i]));
         check("shr4_cnt", 64'(bc4), 64'(shr_cnt[i]));
         check("shr4_wd",  64'(wd4), (i == 3) ? 64'd1 : 64'd0);
      end
      step(1'b1, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
      check("shr4_wd_end", 64'(wd4), 64'd0);

      // Rotates, arithmetic shift and left shift on the 8-bit instance.
      step(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
      step(1'b1, 1'b1, MODE_ROL,  1'b0, 1'b0, 8'h00);
      check("rol_03", 64'(q8), 64'h03);
      step(1'b1, 1'b1, MODE_ROR,  1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, MODE_ROR,  1'b0, 1'b0, 8'h00);
      check("ror_c0", 64'(q8), 64'hC0);
      step(1'b1, 1'b1, MODE_ASR,  1'b0, 1'b0, 8'h00);
      check("asr_e0", 64'(q8), 64'hE0);
      step(1'b1, 1'b1, MODE_SHL,  1'b0, 1'b1, 8'h00);
      check("shl_c1", 64'(q8), 64'hC1);

      // Disabled shifts are holds.
      step(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, MODE_SHR, 1'b1, 1'b1, 8'h00);
         check("en0_q8",   64'(q8),  64'h3C);
         check("en0_cnt8", 64'(bc8), 64'd0);
         check("en0_wd8",  64'(wd8), 64'd0);
      end

      // Clear mid-word restarts the count.
      step(1'b1, 1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, MODE_CLR, 1'b0, 1'b0, 8'h00);
      check("clr_q4",   64'(q4),  64'd0);
      check("clr_cnt4", 64'(bc4), 64'd0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, (i < 4) ? MODE_SHR : MODE_HOLD, 1'b1, 1'b0, 8'h00);
         if (wd4) pulses++;
      end
      check("clr_pulses", 64'(pulses), 64'd1);

      // Reset at the third shift discards the partial word.
      step(1'b1, 1'b1, MODE_CLR, 1'b0, 1'b0, 8'h00);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step((i == 2) ? 1'b0 : 1'b1, 1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
         if (wd4) pulses++;
      end
      check("rst_pulses", 64'(pulses), 64'd0);

      // Continuous shifting: a pulse every 4 cycles with no gap.
      step(1'b1, 1'b1, MODE_CLR, 1'b0, 1'b0, 8'h00);
      pulses = 0;
      last_pulse = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, MODE_SHR, 1'(i & 1), 1'b0, 8'h00);
         if (wd4) begin
            if (last_pulse >= 0) check("cont_gap", 64'(i - last_pulse), 64'd4);
            last_pulse = i;
            pulses++;
         end
      end
      check("cont_pulses", 64'(pulses), 64'd3);

      // Randomised operation mix with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
              mode_t'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_univ_shiftreg
